// File: rtl/uartlite_tx_master.sv
// uartlite_tx_master
//   AXI4-Lite initiator that moves bytes from the stdout stream into the
//   Xilinx AXI UART Lite TX FIFO. Bytes are buffered locally. For each byte
//   the block polls STAT (0x8) until TX_FULL (bit 3) is clear, writes the byte
//   to TX FIFO (0x4), waits for BRESP and then pops it. Optionally, a single
//   CTRL (0xC) = 0x3 write after reset clears the UART FIFOs.
//   Only one AXI transaction is outstanding at a time.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   s_data_i/valid/ready    byte input stream (registered ready)
//   m_aw*/m_w*/m_b*         AXI4-Lite write channels
//   m_ar*/m_r*              AXI4-Lite read channels (STAT polling only)
//   busy_o                  bytes pending or a transaction in flight
//   err_o                   sticky: any non-OKAY BRESP/RRESP seen
module uartlite_tx_master #(
  parameter int FIFO_DEPTH       = 8,
  parameter bit INIT_RESET_FIFOS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [3:0]  m_awaddr_o,
  output logic        m_awvalid_o,
  input  logic        m_awready_i,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  output logic        m_wvalid_o,
  input  logic        m_wready_i,
  input  logic [1:0]  m_bresp_i,
  input  logic        m_bvalid_i,
  output logic        m_bready_o,
  output logic [3:0]  m_araddr_o,
  output logic        m_arvalid_o,
  input  logic        m_arready_i,
  input  logic [31:0] m_rdata_i,
  input  logic [1:0]  m_rresp_i,
  input  logic        m_rvalid_i,
  output logic        m_rready_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_AR   = 3'd2;
  localparam logic [2:0] S_R    = 3'd3;
  localparam logic [2:0] S_AW_W = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  logic [2:0]    state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          init_pending, init_pending_n;
  logic          aw_done, w_done;
  logic          s_ready_q, busy_q, err_q;
  logic [3:0]    araddr_q;
  wr_req_t       wr_q;
  logic          push, pop, aw_hs, w_hs, b_hs, r_hs;
  logic          unused_rdata;

  assign unused_rdata = ^{m_rdata_i[31:4], m_rdata_i[2:0]};

  // Valid/ready outputs decode registered state only, so reset drops them
  // asynchronously together with the state register.
  assign m_arvalid_o = (state == S_AR);
  assign m_rready_o  = (state == S_R);
  assign m_awvalid_o = (state == S_AW_W) && !aw_done;
  assign m_wvalid_o  = (state == S_AW_W) && !w_done;
  assign m_bready_o  = (state == S_B);
  assign m_awaddr_o  = wr_q.addr;
  assign m_wdata_o   = wr_q.data;
  assign m_wstrb_o   = 4'hF;
  assign m_araddr_o  = araddr_q;
  assign s_ready_o   = s_ready_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

  assign aw_hs = m_awvalid_o & m_awready_i;
  assign w_hs  = m_wvalid_o & m_wready_i;
  assign r_hs  = m_rready_o & m_rvalid_i;
  assign b_hs  = m_bready_o & m_bvalid_i;
  assign push  = s_valid_i & s_ready_q;
  // The CTRL write borrows AW_W/B but has no FIFO entry behind it.
  assign pop   = b_hs & !init_pending;

  assign count_n        = count + (AW+1)'(push) - (AW+1)'(pop);
  assign init_pending_n = init_pending & !b_hs;

  always_comb begin
    state_n = state;
    case (state)
      S_INIT: state_n = S_AW_W;
      S_IDLE: if (count != '0) state_n = S_AR;
      S_AR:   if (m_arready_i) state_n = S_R;
      S_R:    if (m_rvalid_i) begin
                if (m_rresp_i != 2'b00 || m_rdata_i[3]) state_n = S_AR;
                else                                    state_n = S_AW_W;
              end
      S_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = S_B;
      S_B:    if (m_bvalid_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT_RESET_FIFOS ? S_INIT : S_IDLE;
      init_pending <= INIT_RESET_FIFOS;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      wr_q         <= '0;
      araddr_q     <= 4'h0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_n;
      init_pending <= init_pending_n;
      count        <= count_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      aw_done <= (state == S_AW_W) && (aw_done || aw_hs);
      w_done  <= (state == S_AW_W) && (w_done || w_hs);
      // Head is stable until the pop in B, so latch the beat on entry.
      if (state_n == S_AW_W && state != S_AW_W)
        wr_q <= init_pending ? wr_req_t'{addr: 4'hC, data: 32'h3}
                             : wr_req_t'{addr: 4'h4, data: {24'h0, mem[rd_ptr]}};
      if (state_n == S_AR) araddr_q <= 4'h8;
      if ((r_hs && m_rresp_i != 2'b00) || (b_hs && m_bresp_i != 2'b00))
        err_q <= 1'b1;
      s_ready_q <= (count_n != FULL_CNT) && !init_pending_n;
      busy_q    <= (count_n != '0) || (state_n != S_IDLE);
    end
  end
endmodule

// File: tb/tb_uartlite_tx_master.sv
// Self-checking bench for uartlite_tx_master: behavioural UART Lite slave,
// handshake monitor, a table of single-byte transfers and hand-written
// sequences for init, ordering, FIFO full and mid-transfer reset.
module tb_uartlite_tx_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [3:0]  m_awaddr_o;
  logic        m_awvalid_o;
  logic        m_awready_i;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_wvalid_o;
  logic        m_wready_i;
  logic [1:0]  m_bresp_i;
  logic        m_bvalid_i;
  logic        m_bready_o;
  logic [3:0]  m_araddr_o;
  logic        m_arvalid_o;
  logic        m_arready_i;
  logic [31:0] m_rdata_i;
  logic [1:0]  m_rresp_i;
  logic        m_rvalid_i;
  logic        m_rready_o;
  logic        busy_o;
  logic        err_o;

  uartlite_tx_master #(.FIFO_DEPTH(8), .INIT_RESET_FIFOS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i),
    .m_bready_o(m_bready_o), .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o),
    .m_arready_i(m_arready_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // slave configuration
  int         stat_busy = 0;
  bit         stat_hold = 1'b0;
  int         aw_delay  = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int         aw_wait   = 0;

  // monitor state
  int          ar_cnt = 0, b_cnt = 0;
  int          awv_run = 0, wv_run = 0, last_aw_len = 0, last_w_len = 0;
  logic [3:0]  aw_q[$];
  logic [31:0] wd_q[$];

  int checks = 0, failures = 0;

  // Slave drives its inputs on the falling edge from the valids it sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_arready_i = 0; m_rvalid_i = 0; m_rdata_i = 0; m_rresp_i = 0;
      m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 0;
      aw_wait = 0;
    end else begin
      m_arready_i = m_arvalid_o;
      m_rvalid_i  = m_rready_o;
      m_rdata_i   = (stat_hold || stat_busy > 0) ? 32'h8 : 32'h0;
      m_rresp_i   = 2'b00;
      if (m_awvalid_o) aw_wait = aw_wait + 1; else aw_wait = 0;
      m_awready_i = m_awvalid_o && (aw_wait > aw_delay);
      m_wready_i  = m_wvalid_o;
      m_bvalid_i  = m_bready_o;
      m_bresp_i   = bresp_cfg;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_arvalid_o && m_arready_i) ar_cnt++;
      if (m_rvalid_i && m_rready_o && stat_busy > 0) stat_busy--;
      if (m_awvalid_o) awv_run++;
      if (m_wvalid_o)  wv_run++;
      if (m_awvalid_o && m_awready_i) begin
        aw_q.push_back(m_awaddr_o); last_aw_len = awv_run; awv_run = 0;
      end
      if (m_wvalid_o && m_wready_i) begin
        wd_q.push_back(m_wdata_o); last_w_len = wv_run; wv_run = 0;
      end
      if (m_bvalid_i && m_bready_o) b_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    s_data_i = b; s_valid_i = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (s_ready_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; end
    s_valid_i = 1'b0;
  endtask

  task automatic wait_b(input int target, input string name);
    int t = 0;
    while (b_cnt < target && t < 3000) begin @(negedge clk); t++; end
    chk(name, 32'(b_cnt >= target), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         stat_busy;
    int         aw_delay;
    logic [1:0] bresp;
    int         exp_ars;
    int         exp_aw_len;
    int         exp_w_len;
    logic       exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit ok;
    int b0, ar0, base, aw_sz;

    vecs[0] = '{8'hA5, 3, 0, 2'b00, 4, 1, 1, 1'b0};
    vecs[1] = '{8'h3C, 0, 3, 2'b10, 1, 4, 1, 1'b1};
    vecs[2] = '{8'h00, 0, 0, 2'b00, 1, 1, 1, 1'b1};
    vecs[3] = '{8'hFF, 1, 2, 2'b00, 2, 3, 1, 1'b1};

    rst_n = 1'b0; s_data_i = 8'h0; s_valid_i = 1'b0;
    m_arready_i = 0; m_rvalid_i = 0; m_rdata_i = 0; m_rresp_i = 0;
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 0;
    repeat (3) @(negedge clk);

    chk("rst_valids", 32'({m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o}), 32'h0);
    chk("rst_s_ready", 32'(s_ready_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_addr", 32'({m_awaddr_o, m_araddr_o}), 32'h0);
    chk("rst_wdata", m_wdata_o, 32'h0);
    rst_n = 1'b1;

    // CTRL init write
    wait_b(1, "init_b");
    repeat (2) @(negedge clk);
    chk("init_awaddr", 32'(aw_q[0]), 32'hC);
    chk("init_wdata", wd_q[0], 32'h3);
    chk("init_nwrites", 32'(aw_q.size()), 32'd1);
    chk("init_s_ready", 32'(s_ready_o), 32'h1);
    chk("init_busy", 32'(busy_o), 32'h0);
    chk("init_no_ar", 32'(ar_cnt), 32'd0);

    // "Hi" in order, busy falls after second B
    b0 = b_cnt; base = wd_q.size();
    push(8'h48, ok); chk("hi_push0", 32'(ok), 32'h1);
    push(8'h69, ok); chk("hi_push1", 32'(ok), 32'h1);
    wait_b(b0 + 1, "hi_b0");
    chk("hi_busy_mid", 32'(busy_o), 32'h1);
    wait_b(b0 + 2, "hi_b1");
    chk("hi_busy_end", 32'(busy_o), 32'h0);
    chk("hi_wd0", wd_q[base], 32'h48);
    chk("hi_wd1", wd_q[base + 1], 32'h69);
    chk("hi_awaddr", 32'(aw_q[aw_q.size() - 1]), 32'h4);
    chk("hi_wstrb", 32'(m_wstrb_o), 32'hF);

    // single-byte table
    for (int i = 0; i < 4; i++) begin
      stat_busy = vecs[i].stat_busy;
      aw_delay  = vecs[i].aw_delay;
      bresp_cfg = vecs[i].bresp;
      ar0 = ar_cnt; b0 = b_cnt; base = wd_q.size(); aw_sz = aw_q.size();
      push(vecs[i].data, ok);
      chk($sformatf("row%0d_push", i), 32'(ok), 32'h1);
      wait_b(b0 + 1, $sformatf("row%0d_b", i));
      @(negedge clk);
      chk($sformatf("row%0d_nwrites", i), 32'(wd_q.size() - base), 32'd1);
      chk($sformatf("row%0d_awaddr", i), 32'(aw_q[aw_sz]), 32'h4);
      chk($sformatf("row%0d_wdata", i), wd_q[base], {24'h0, vecs[i].data});
      chk($sformatf("row%0d_ars", i), 32'(ar_cnt - ar0), 32'(vecs[i].exp_ars));
      chk($sformatf("row%0d_awlen", i), 32'(last_aw_len), 32'(vecs[i].exp_aw_len));
      chk($sformatf("row%0d_wlen", i), 32'(last_w_len), 32'(vecs[i].exp_w_len));
      chk($sformatf("row%0d_err", i), 32'(err_o), 32'(vecs[i].exp_err));
      bresp_cfg = 2'b00;
    end
    aw_delay = 0; stat_busy = 0;

    // FIFO full: TX_FULL held, 9 bytes into 8 entries
    stat_hold = 1'b1; b0 = b_cnt; base = wd_q.size();
    for (int i = 0; i < 8; i++) begin
      push(8'h10 + 8'(i), ok);
      chk($sformatf("full_push%0d", i), 32'(ok), 32'h1);
    end
    @(negedge clk);
    chk("full_s_ready", 32'(s_ready_o), 32'h0);
    s_data_i = 8'h18; s_valid_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("full_held", 32'(s_ready_o), 32'h0);
    chk("full_no_write", 32'(wd_q.size() - base), 32'd0);
    stat_hold = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (s_ready_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; end
    s_valid_i = 1'b0;
    chk("full_push8", 32'(ok), 32'h1);
    wait_b(b0 + 9, "full_b");
    for (int i = 0; i < 9; i++) begin
      logic [7:0] eb;
      eb = 8'h10 + 8'(i);
      chk($sformatf("full_wd%0d", i), wd_q[base + i], {24'h0, eb});
    end

    // reset while in AW_W
    aw_delay = 20;
    push(8'h77, ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (m_awvalid_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("rstmid_in_aw", 32'(ok), 32'h1);
    ar0 = ar_cnt; b0 = b_cnt; aw_sz = aw_q.size();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valids", 32'({m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o}), 32'h0);
    chk("rstmid_s_ready", 32'(s_ready_o), 32'h0);
    chk("rstmid_err", 32'(err_o), 32'h0);
    aw_delay = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_b(b0 + 1, "rstmid_init_b");
    repeat (5) @(negedge clk);
    chk("rstmid_init_addr", 32'(aw_q[aw_q.size() - 1]), 32'hC);
    chk("rstmid_nwrites", 32'(aw_q.size() - aw_sz), 32'd1);
    chk("rstmid_busy", 32'(busy_o), 32'h0);
    chk("rstmid_no_ar", 32'(ar_cnt - ar0), 32'd0);
    chk("rstmid_s_ready1", 32'(s_ready_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
